// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int REG_NUM = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // Width of the head-of-queue wait counter; covers MAX_WAIT up to 15.
    localparam int AGE_W = 4;

    // One queued MDU result waiting for a free write slot.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    // Which writer owns the register-file port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_MDU  = 2'd2
    } arb_src_e;

    // A register is pending while an MDU result is outstanding for it, except in the
    // cycle that result drains, because the register file bypasses same-cycle writes.
    function automatic logic isPending(
        input logic [REG_NUM-1:0] busy,
        input logic [REG_AW-1:0]  addr,
        input logic               drain,
        input logic [REG_AW-1:0]  drainAddr
    );
        return busy[addr] & ~(drain & (drainAddr == addr));
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small power-of-two FIFO holding MDU results until the write port is free.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_wdata,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_doPush;
    logic            w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_head   = r_mem[r_rptr];

    // Storage needs no reset: nothing reads an entry before it has been written.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count is unchanged on simultaneous push and pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the WB stage and queued MDU results,
// and tracks MDU destinations so ID stalls on registers whose result is still pending.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pipe_we_i,
    input  logic [REG_AW-1:0] pipe_addr_i,
    input  logic [REG_DW-1:0] pipe_data_i,
    input  logic              mdu_valid_i,
    output logic              mdu_ready_o,
    input  logic [REG_AW-1:0] mdu_addr_i,
    input  logic [REG_DW-1:0] mdu_data_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_we_i,
    input  logic              id_mdu_i,
    input  logic              id_fire_i,
    output logic              stall_o,
    output logic              starve_o,
    output logic              RegWrite_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic [REG_DW-1:0] RDdata_o
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    logic                w_pipeSlot;
    logic                w_drain;
    logic                w_push;
    logic                w_issue;
    logic                w_fifoFull;
    logic                w_fifoEmpty;
    wb_entry_t           w_pushEntry;
    wb_entry_t           w_head;
    arb_src_e            w_src;
    logic [REG_NUM-1:0]  r_busy;
    logic [REG_NUM-1:0]  w_busyNext;
    logic [AGE_W-1:0]    r_age;
    logic [AGE_W-1:0]    w_ageNext;

    // Writes to r0 are no-ops, so they never consume the port.
    assign w_pipeSlot = pipe_we_i & (pipe_addr_i != REG_ZERO);
    assign w_drain    = ~w_pipeSlot & ~w_fifoEmpty;

    // Readiness looks only at the registered fill level, so a full FIFO refuses even while draining.
    assign mdu_ready_o = ~w_fifoFull;

    // Results aimed at r0 are accepted but never queued.
    assign w_push = mdu_valid_i & mdu_ready_o & (mdu_addr_i != REG_ZERO);
    assign w_issue = id_fire_i & id_mdu_i & (id_rd_i != REG_ZERO);

    assign w_pushEntry.addr = mdu_addr_i;
    assign w_pushEntry.data = mdu_data_i;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_push  (w_push),
        .i_pop   (w_drain),
        .i_wdata (w_pushEntry),
        .o_head  (w_head),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    // Pipeline owns the port whenever it writes; otherwise the FIFO head drains into the free slot.
    always_comb begin
        w_src = SRC_NONE;
        if (w_pipeSlot) begin
            w_src = SRC_PIPE;
        end else if (!w_fifoEmpty) begin
            w_src = SRC_MDU;
        end
    end

    // Drive the register-file write port from whichever writer won.
    always_comb begin
        RegWrite_o = 1'b0;
        RDaddr_o   = REG_ZERO;
        RDdata_o   = '0;
        unique case (w_src)
            SRC_PIPE: begin
                RegWrite_o = 1'b1;
                RDaddr_o   = pipe_addr_i;
                RDdata_o   = pipe_data_i;
            end
            SRC_MDU: begin
                RegWrite_o = 1'b1;
                RDaddr_o   = w_head.addr;
                RDdata_o   = w_head.data;
            end
            default: begin
                RegWrite_o = 1'b0;
            end
        endcase
    end

    // Clear on drain first so a same-cycle re-issue to that register keeps it busy.
    always_comb begin
        w_busyNext = r_busy;
        if (w_drain) begin
            w_busyNext[w_head.addr] = 1'b0;
        end
        if (w_issue) begin
            w_busyNext[id_rd_i] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // Scoreboard of MDU destinations still outstanding.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    // Hold ID on a read or write of a register the MDU still owes.
    always_comb begin
        stall_o = isPending(r_busy, id_rs_i, w_drain, w_head.addr)
                | isPending(r_busy, id_rt_i, w_drain, w_head.addr)
                | (id_rd_we_i & isPending(r_busy, id_rd_i, w_drain, w_head.addr));
    end

    // Count cycles the head has been blocked by the pipeline, saturating at the threshold.
    always_comb begin
        w_ageNext = r_age;
        if (w_fifoEmpty || w_drain) begin
            w_ageNext = '0;
        end else if (r_age != AGE_MAX) begin
            w_ageNext = r_age + 1'b1;
        end
    end

    // Head-of-queue wait counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_age <= '0;
        end else begin
            r_age <= w_ageNext;
        end
    end

    assign starve_o = (r_age == AGE_MAX);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter with a scoreboard of queued MDU results.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rstN;
    logic        pipeWe;
    logic [4:0]  pipeAddr;
    logic [31:0] pipeData;
    logic        mduValid;
    logic        mduReady;
    logic [4:0]  mduAddr;
    logic [31:0] mduData;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic [4:0]  idRd;
    logic        idRdWe;
    logic        idMdu;
    logic        idFire;
    logic        stall;
    logic        starve;
    logic        regWrite;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;

    typedef struct {
        logic        rstLow;
        logic        pipeWe;
        logic [4:0]  pipeAddr;
        logic [31:0] pipeData;
        logic        mduValid;
        logic [4:0]  mduAddr;
        logic [31:0] mduData;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rdWe;
        logic        idMdu;
        logic        idFire;
        logic        expWe;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic        expReady;
        logic        expStall;
        logic        expStarve;
    } vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbQ[$];
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rstN),
        .pipe_we_i   (pipeWe),
        .pipe_addr_i (pipeAddr),
        .pipe_data_i (pipeData),
        .mdu_valid_i (mduValid),
        .mdu_ready_o (mduReady),
        .mdu_addr_i  (mduAddr),
        .mdu_data_i  (mduData),
        .id_rs_i     (idRs),
        .id_rt_i     (idRt),
        .id_rd_i     (idRd),
        .id_rd_we_i  (idRdWe),
        .id_mdu_i    (idMdu),
        .id_fire_i   (idFire),
        .stall_o     (stall),
        .starve_o    (starve),
        .RegWrite_o  (regWrite),
        .RDaddr_o    (rdAddr),
        .RDdata_o    (rdData)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        int rl, int pWe, int pA, int pD, int mV, int mA, int mD,
        int rs, int rt, int rd, int rdWe, int iMdu, int fire,
        int eWe, int eA, int eD, int eRdy, int eStall, int eStarve
    );
        vec_t v;
        v.rstLow    = (rl != 0);
        v.pipeWe    = (pWe != 0);
        v.pipeAddr  = 5'(pA);
        v.pipeData  = 32'(pD);
        v.mduValid  = (mV != 0);
        v.mduAddr   = 5'(mA);
        v.mduData   = 32'(mD);
        v.rs        = 5'(rs);
        v.rt        = 5'(rt);
        v.rd        = 5'(rd);
        v.rdWe      = (rdWe != 0);
        v.idMdu     = (iMdu != 0);
        v.idFire    = (fire != 0);
        v.expWe     = (eWe != 0);
        v.expAddr   = 5'(eA);
        v.expData   = 32'(eD);
        v.expReady  = (eRdy != 0);
        v.expStall  = (eStall != 0);
        v.expStarve = (eStarve != 0);
        return v;
    endfunction

    function automatic void add(
        int rl, int pWe, int pA, int pD, int mV, int mA, int mD,
        int rs, int rt, int rd, int rdWe, int iMdu, int fire,
        int eWe, int eA, int eD, int eRdy, int eStall, int eStarve
    );
        vecs.push_back(mk(rl, pWe, pA, pD, mV, mA, mD, rs, rt, rd, rdWe, iMdu, fire,
                          eWe, eA, eD, eRdy, eStall, eStarve));
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rstN     = ~v.rstLow;
        pipeWe   = v.pipeWe;
        pipeAddr = v.pipeAddr;
        pipeData = v.pipeData;
        mduValid = v.mduValid;
        mduAddr  = v.mduAddr;
        mduData  = v.mduData;
        idRs     = v.rs;
        idRt     = v.rt;
        idRd     = v.rd;
        idRdWe   = v.rdWe;
        idMdu    = v.idMdu;
        idFire   = v.idFire;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        logic slot;
        sb_t  e;
        checkVal({tag, "_we"},     32'(regWrite), 32'(v.expWe));
        checkVal({tag, "_addr"},   32'(rdAddr),   32'(v.expAddr));
        checkVal({tag, "_data"},   rdData,        v.expData);
        checkVal({tag, "_ready"},  32'(mduReady), 32'(v.expReady));
        checkVal({tag, "_stall"},  32'(stall),    32'(v.expStall));
        checkVal({tag, "_starve"}, 32'(starve),   32'(v.expStarve));
        if (v.rstLow) begin
            sbQ.delete();
        end
        slot = v.pipeWe && (v.pipeAddr != 5'd0);
        if (!slot && sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkVal({tag, "_sbWe"},   32'(regWrite), 32'd1);
            checkVal({tag, "_sbAddr"}, 32'(rdAddr),   32'(e.addr));
            checkVal({tag, "_sbData"}, rdData,        e.data);
        end
        if (!v.rstLow && v.mduValid && v.expReady && v.mduAddr != 5'd0) begin
            e.addr = v.mduAddr;
            e.data = v.mduData;
            sbQ.push_back(e);
        end
    endtask

    // Drive on the falling edge, sample 2 ns later, commit on the next rising edge.
    task automatic stepCheck(input string tag, input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #2;
        checkOutput(tag, v);
    endtask

    initial begin
        vec_t v;
        int   waited;

        rstN = 1'b0; pipeWe = 1'b0; pipeAddr = '0; pipeData = '0;
        mduValid = 1'b0; mduAddr = '0; mduData = '0;
        idRs = '0; idRt = '0; idRd = '0; idRdWe = 1'b0; idMdu = 1'b0; idFire = 1'b0;

        // rl, pipe(we,addr,data), mdu(v,addr,data), id(rs,rt,rd,rdWe,mdu,fire), exp(we,addr,data,rdy,stall,starve)
        // Reset, then a lone MDU result drains the next cycle.
        add(1, 0,0,0,      0,0,0,        0,0,0,0,0,0, 0,0,0,        1,0,0);
        add(0, 0,0,0,      0,0,0,        0,0,0,0,0,0, 0,0,0,        1,0,0);
        add(0, 0,0,0,      1,5,'h1234,   0,0,0,0,0,0, 0,0,0,        1,0,0);
        add(0, 0,0,0,      0,0,0,        0,0,0,0,0,0, 1,5,'h1234,   1,0,0);
        add(0, 0,0,0,      0,0,0,        0,0,0,0,0,0, 0,0,0,        1,0,0);
        // Pipeline hogs the port; head starves after four blocked cycles.
        add(0, 1,3,'hA0,   1,7,'h77,     0,0,0,0,0,0, 1,3,'hA0,     1,0,0);
        add(0, 1,3,'hA1,   0,0,0,        0,0,0,0,0,0, 1,3,'hA1,     1,0,0);
        add(0, 1,3,'hA2,   0,0,0,        0,0,0,0,0,0, 1,3,'hA2,     1,0,0);
        add(0, 1,3,'hA3,   0,0,0,        0,0,0,0,0,0, 1,3,'hA3,     1,0,0);
        add(0, 1,3,'hA4,   0,0,0,        0,0,0,0,0,0, 1,3,'hA4,     1,0,0);
        add(0, 1,3,'hA5,   0,0,0,        0,0,0,0,0,0, 1,3,'hA5,     1,0,1);
        add(0, 0,0,0,      0,0,0,        0,0,0,0,0,0, 1,7,'h77,     1,0,1);
        add(0, 0,3,'hFF,   0,0,0,        0,0,0,0,0,0, 0,0,0,        1,0,0);
        // Scoreboard: issue to r9, stall until its drain cycle, re-issue in that cycle.
        add(0, 0,0,0,      0,0,0,        0,0,9,1,1,1, 0,0,0,        1,0,0);
        add(0, 0,0,0,      0,0,0,        9,0,0,0,0,0, 0,0,0,        1,1,0);
        add(0, 0,0,0,      0,0,0,        0,0,9,0,0,0, 0,0,0,        1,0,0);
        add(0, 0,0,0,      0,0,0,        0,0,9,1,0,0, 0,0,0,        1,1,0);
        add(0, 0,0,0,      1,9,'h99,     9,0,0,0,0,0, 0,0,0,        1,1,0);
        add(0, 1,3,'hB0,   0,0,0,        9,0,0,0,0,0, 1,3,'hB0,     1,1,0);
        add(0, 0,0,0,      0,0,0,        9,0,9,1,1,1, 1,9,'h99,     1,0,0);
        add(0, 0,0,0,      0,0,0,        0,9,0,0,0,0, 0,0,0,        1,1,0);
        add(0, 0,0,0,      1,9,'h9A,     0,9,0,0,0,0, 0,0,0,        1,1,0);
        add(0, 0,0,0,      0,0,0,        0,9,0,0,0,0, 1,9,'h9A,     1,0,0);
        add(0, 0,0,0,      0,0,0,        9,9,9,1,0,0, 0,0,0,        1,0,0);
        // Full FIFO refuses a third result until the count drops; order kept.
        add(0, 1,3,'hC0,   1,10,'h10A,   0,0,0,0,0,0, 1,3,'hC0,     1,0,0);
        add(0, 1,3,'hC1,   1,11,'h10B,   0,0,0,0,0,0, 1,3,'hC1,     1,0,0);
        add(0, 1,3,'hC2,   1,12,'h10C,   0,0,0,0,0,0, 1,3,'hC2,     0,0,0);
        add(0, 0,0,0,      1,12,'h10C,   0,0,0,0,0,0, 1,10,'h10A,   0,0,0);
        add(0, 0,0,0,      1,12,'h10C,   0,0,0,0,0,0, 1,11,'h10B,   1,0,0);
        add(0, 0,0,0,      0,0,0,        0,0,0,0,0,0, 1,12,'h10C,   1,0,0);
        add(0, 0,0,0,      0,0,0,        0,0,0,0,0,0, 0,0,0,        1,0,0);
        // A pipe write to r0 leaves the slot free; an MDU result to r0 is dropped.
        add(0, 0,0,0,      1,13,'hD0,    0,0,0,0,0,0, 0,0,0,        1,0,0);
        add(0, 1,0,'hDEAD, 1,0,'hEE,     0,0,0,0,0,0, 1,13,'hD0,    1,0,0);
        add(0, 0,0,0,      0,0,0,        0,0,0,0,0,0, 0,0,0,        1,0,0);
        // Reset with two queued entries and r4 busy.
        add(0, 1,3,'hE0,   1,4,'h44,     0,0,4,1,1,1, 1,3,'hE0,     1,0,0);
        add(0, 1,3,'hE1,   1,6,'h66,     0,0,0,0,0,0, 1,3,'hE1,     1,0,0);
        add(0, 1,3,'hE2,   0,0,0,        4,0,0,0,0,0, 1,3,'hE2,     0,1,0);
        add(1, 0,0,0,      0,0,0,        4,0,0,0,0,0, 0,0,0,        1,0,0);
        add(0, 0,0,0,      0,0,0,        4,0,0,0,0,0, 0,0,0,        1,0,0);

        repeat (2) @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            stepCheck($sformatf("row%0d", i), vecs[i]);
        end

        // Starvation latency measured with a bounded wait, then saturation and release.
        v = mk(0, 1,3,'hF0, 1,8,'h88, 0,0,0,0,0,0, 1,3,'hF0, 1,0,0);
        stepCheck("starvePush", v);
        waited = 0;
        v = mk(0, 1,3,'hF1, 0,0,0, 0,0,0,0,0,0, 1,3,'hF1, 1,0,0);
        do begin
            @(negedge clk);
            applyStimulus(v);
            #2;
            waited++;
        end while (starve !== 1'b1 && waited < 20);
        checkVal("starveLatency", 32'(waited), 32'd5);
        v = mk(0, 1,3,'hF2, 0,0,0, 0,0,0,0,0,0, 1,3,'hF2, 1,0,1);
        stepCheck("starveSat1", v);
        stepCheck("starveSat2", v);
        v = mk(0, 0,0,0, 0,0,0, 0,0,0,0,0,0, 1,8,'h88, 1,0,1);
        stepCheck("starveDrain", v);
        v = mk(0, 0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0, 1,0,0);
        stepCheck("starveClear", v);

        checkVal("sbEmpty", 32'(sbQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
